// File: rtl/mx_mul_bf16_pipe.sv
// ============================================================================
// Module      : mx_mul_bf16_pipe
// Description : Two-stage per-lane MX block-float multiplier producing packed
//               BF16 products. Define MX_MUL_RNE_EN for round-to-nearest-even;
//               otherwise rounding is half-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mx_mul_bf16_pipe #(
    parameter int MANT_WIDTH = 5,
    parameter int LANES      = 4,
    parameter int BIAS       = 127
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            sign_a,
    input  logic [LANES-1:0]            sign_b,
    input  logic [LANES*MANT_WIDTH-1:0] mant_a,
    input  logic [LANES*MANT_WIDTH-1:0] mant_b,
    input  logic [7:0]                  exp_a,
    input  logic [7:0]                  exp_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*16-1:0]         bf16_out,
    output logic [LANES-1:0]            lane_ovf,
    output logic [LANES-1:0]            lane_unf,
    output logic [15:0]                 ovf_count,
    input  logic                        clr_count
);

    localparam int c_SIG_W  = MANT_WIDTH + 1;
    localparam int c_PROD_W = 2 * c_SIG_W;
    localparam int c_FRAC_W = 2 * MANT_WIDTH + 1;
    localparam int c_EXT_W  = c_FRAC_W + 9;
`ifdef MX_MUL_RNE_EN
    localparam bit c_RNE = 1'b1;
`else
    localparam bit c_RNE = 1'b0;
`endif

    // Pipeline state
    logic                        r_s1_valid;
    logic [LANES*c_PROD_W-1:0]   r_prod;
    logic [LANES-1:0]            r_sign;
    logic signed [9:0]           r_exp;
    logic                        r_zero;
    logic                        r_s2_valid;
    logic [LANES*16-1:0]         r_out;
    logic [LANES-1:0]            r_ovf;
    logic [LANES-1:0]            r_unf;
    logic [15:0]                 r_ovf_count;

    logic                        w_s2_adv;
    logic                        w_s1_load;
    logic                        w_s2_load;
    logic [LANES*c_PROD_W-1:0]   w_prod_in;
    logic signed [9:0]           w_exp_sum;
    logic [LANES*16-1:0]         w_res_bus;
    logic [LANES-1:0]            w_ovf_bus;
    logic [LANES-1:0]            w_unf_bus;
    logic [16:0]                 w_ovf_pop;
    logic [16:0]                 w_ovf_sum;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_s2_adv;
    assign w_exp_sum = 10'(exp_a) + 10'(exp_b) - 10'(BIAS);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [c_PROD_W-1:0] w_sa;
            logic [c_PROD_W-1:0] w_sb;
            logic [c_PROD_W-1:0] w_prod;
            logic [c_FRAC_W-1:0] w_frac;
            logic [c_EXT_W-1:0]  w_ext;
            logic signed [11:0]  w_exp_norm;
            logic signed [11:0]  w_exp_fin;
            logic [6:0]          w_mant;
            logic                w_guard;
            logic                w_sticky;
            logic                w_inc;
            logic [7:0]          w_mant_rnd;
            logic [15:0]         w_res;
            logic                w_ovf;
            logic                w_unf;

            assign w_sa = {{(c_PROD_W-c_SIG_W){1'b0}}, 1'b1, mant_a[i*MANT_WIDTH +: MANT_WIDTH]};
            assign w_sb = {{(c_PROD_W-c_SIG_W){1'b0}}, 1'b1, mant_b[i*MANT_WIDTH +: MANT_WIDTH]};
            assign w_prod_in[i*c_PROD_W +: c_PROD_W] = w_sa * w_sb;
            assign w_prod = r_prod[i*c_PROD_W +: c_PROD_W];

            always_comb begin
                // Left-align the fraction so the rounding taps sit at fixed positions
                if (w_prod[c_PROD_W-1]) begin
                    w_frac     = w_prod[c_FRAC_W-1:0];
                    w_exp_norm = {{2{r_exp[9]}}, r_exp} + 12'sd1;
                end else begin
                    w_frac     = {w_prod[c_FRAC_W-2:0], 1'b0};
                    w_exp_norm = {{2{r_exp[9]}}, r_exp};
                end
                w_ext      = {w_frac, 9'b0};
                w_mant     = w_ext[c_EXT_W-1 -: 7];
                w_guard    = w_ext[c_EXT_W-8];
                w_sticky   = |w_ext[c_EXT_W-9:0];
                w_inc      = c_RNE ? (w_guard & (w_sticky | w_mant[0])) : w_guard;
                w_mant_rnd = {1'b0, w_mant} + {7'b0, w_inc};
                w_exp_fin  = w_exp_norm + $signed({11'b0, w_mant_rnd[7]});

                w_res = {r_sign[i], 15'b0};
                w_ovf = 1'b0;
                w_unf = 1'b0;
                if (r_zero) begin
                    w_res = {r_sign[i], 15'b0};
                end else if (w_exp_fin <= 12'sd0) begin
                    w_unf = 1'b1;
                end else if (w_exp_fin >= 12'sd255) begin
                    w_res = {r_sign[i], 8'hFF, 7'b0};
                    w_ovf = 1'b1;
                end else begin
                    w_res = {r_sign[i], w_exp_fin[7:0], (w_mant_rnd[7] ? 7'b0 : w_mant_rnd[6:0])};
                end
            end

            assign w_res_bus[i*16 +: 16] = w_res;
            assign w_ovf_bus[i]          = w_ovf;
            assign w_unf_bus[i]          = w_unf;
        end
    endgenerate

    always_comb begin
        w_ovf_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_ovf_pop = w_ovf_pop + 17'(r_ovf[k]);
        end
        w_ovf_sum = {1'b0, r_ovf_count} + w_ovf_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
            r_sign     <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_prod <= w_prod_in;
                r_sign <= sign_a ^ sign_b;
                r_exp  <= w_exp_sum;
                r_zero <= (exp_a == 8'd0) || (exp_b == 8'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_ovf      <= '0;
            r_unf      <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_out <= w_res_bus;
                r_ovf <= w_ovf_bus;
                r_unf <= w_unf_bus;
            end
        end
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (clr_count) begin
            r_ovf_count <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_ovf_count <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
        end
    end

    assign out_valid = r_s2_valid;
    assign bf16_out  = r_out;
    assign lane_ovf  = r_ovf;
    assign lane_unf  = r_unf;
    assign ovf_count = r_ovf_count;

endmodule

`default_nettype wire

// File: tb/tb_mx_mul_bf16_pipe.sv
// ============================================================================
// Module      : tb_mx_mul_bf16_pipe
// Description : Directed self-checking bench for mx_mul_bf16_pipe (4 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mx_mul_bf16_pipe;

`ifdef MX_MUL_RNE_EN
    localparam logic [15:0] c_TIE = 16'h3F90;
`else
    localparam logic [15:0] c_TIE = 16'h3F91;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sign_a, sign_b;
    logic [19:0] mant_a, mant_b;
    logic [7:0]  exp_a, exp_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] bf16_out;
    logic [3:0]  lane_ovf, lane_unf;
    logic [15:0] ovf_count;
    logic        clr_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    mx_mul_bf16_pipe #(.MANT_WIDTH(5), .LANES(4), .BIAS(127)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bf16_out  (bf16_out),
        .lane_ovf  (lane_ovf),
        .lane_unf  (lane_unf),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [19:0] ma, input logic [19:0] mb,
                         input logic [7:0] ea, input logic [7:0] eb);
        sign_a = sa; sign_b = sb; mant_a = ma; mant_b = mb; exp_a = ea; exp_b = eb;
    endtask

    // Entered at posedge+1 with an empty pipeline and out_ready=1
    task automatic run_one(input string tag,
                           input logic [3:0] sa, input logic [3:0] sb,
                           input logic [19:0] ma, input logic [19:0] mb,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic [63:0] want, input logic [3:0] want_ovf,
                           input logic [3:0] want_unf, input logic clr);
        logic [16:0] sum;
        drive(sa, sb, ma, mb, ea, eb);
        in_valid = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " early_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " data"}, bf16_out, want);
        check({tag, " ovf"}, 64'(lane_ovf), 64'(want_ovf));
        check({tag, " unf"}, 64'(lane_unf), 64'(want_unf));
        if (clr) begin
            clr_count = 1'b1;
            exp_cnt   = 16'd0;
        end else begin
            sum     = {1'b0, exp_cnt} + 17'($countones(want_ovf));
            exp_cnt = sum[16] ? 16'hFFFF : sum[15:0];
        end
        @(posedge clk); #1;
        clr_count = 1'b0;
        check({tag, " count"}, 64'(ovf_count), 64'(exp_cnt));
        check({tag, " drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        drive(4'h0, 4'h0, 20'h0, 20'h0, 8'd127, 8'd127);
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst bf16", bf16_out, 64'd0);
        check("rst flags", 64'({lane_ovf, lane_unf}), 64'd0);
        check("rst count", 64'(ovf_count), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        check("release in_ready", 64'(in_ready), 64'd1);

        // Lanes (3..0): 0x1F, tie, 1F*1F, 1.0*1.0
        run_one("mixed", 4'h0, 4'h0, {5'h00, 5'h02, 5'h1F, 5'h00}, {5'h1F, 5'h02, 5'h1F, 5'h00},
                8'd127, 8'd127, {16'h3FFC, c_TIE, 16'h4078, 16'h3F80}, 4'h0, 4'h0, 1'b0);
        run_one("one", 4'h0, 4'h0, 20'h0, 20'h0, 8'd127, 8'd127, {4{16'h3F80}}, 4'h0, 4'h0, 1'b0);
        run_one("max_mant", 4'hF, 4'h0, {4{5'h1F}}, {4{5'h1F}}, 8'd127, 8'd127,
                {4{16'hC078}}, 4'h0, 4'h0, 1'b0);
        run_one("sign_xor", 4'hF, 4'h3, {4{5'h1F}}, {4{5'h1F}}, 8'd127, 8'd127,
                {16'hC078, 16'hC078, 16'h4078, 16'h4078}, 4'h0, 4'h0, 1'b0);
        run_one("tie", 4'h0, 4'h0, {4{5'h02}}, {4{5'h02}}, 8'd127, 8'd127,
                {4{c_TIE}}, 4'h0, 4'h0, 1'b0);
        run_one("exp_zero_edge", 4'h8, 4'h0, {5'h00, 5'h01, 5'h1F, 5'h00}, {5'h00, 5'h1E, 5'h1F, 5'h00},
                8'd1, 8'd126, {16'h8000, 16'h0080, 16'h00F8, 16'h0000}, 4'h0, 4'h9, 1'b0);
        run_one("exp_max_edge", 4'h8, 4'h0, {5'h00, 5'h01, 5'h1F, 5'h00}, {5'h1F, 5'h1E, 5'h1F, 5'h00},
                8'd254, 8'd127, {16'hFF7C, 16'h7F80, 16'h7F80, 16'h7F00}, 4'h6, 4'h0, 1'b0);
        run_one("ovf", 4'h0, 4'h0, 20'h0, 20'h0, 8'd255, 8'd255, {4{16'h7F80}}, 4'hF, 4'h0, 1'b0);
        run_one("ovf_clr", 4'h0, 4'h0, 20'h0, 20'h0, 8'd255, 8'd255, {4{16'h7F80}}, 4'hF, 4'h0, 1'b1);
        run_one("ovf_again", 4'h0, 4'h0, 20'h0, 20'h0, 8'd255, 8'd255, {4{16'h7F80}}, 4'hF, 4'h0, 1'b0);
        run_one("unf", 4'h0, 4'h0, 20'h0, 20'h0, 8'd1, 8'd1, 64'd0, 4'h0, 4'hF, 1'b0);
        run_one("opzero", 4'h2, 4'h0, {4{5'h1F}}, {4{5'h1F}}, 8'd0, 8'd127,
                {16'h0000, 16'h0000, 16'h8000, 16'h0000}, 4'h0, 4'h0, 1'b0);

        // Backpressure: third input must wait, held output must not change
        out_ready = 1'b0;
        drive(4'h0, 4'h0, 20'h0, 20'h0, 8'd127, 8'd127);
        in_valid = 1'b1;
        check("bp accept A", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive(4'h0, 4'h0, {4{5'h1F}}, {4{5'h1F}}, 8'd127, 8'd127);
        check("bp accept B", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive(4'h0, 4'h0, 20'h0, 20'h0, 8'd128, 8'd127);
        check("bp full", 64'(in_ready), 64'd0);
        check("bp valid", 64'(out_valid), 64'd1);
        check("bp A", bf16_out, {4{16'h3F80}});
        @(posedge clk); #1;
        check("bp still full", 64'(in_ready), 64'd0);
        check("bp A held", bf16_out, {4{16'h3F80}});
        out_ready = 1'b1;
        #1;
        check("bp release ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp B valid", 64'(out_valid), 64'd1);
        check("bp B", bf16_out, {4{16'h4078}});
        @(posedge clk); #1;
        check("bp C valid", 64'(out_valid), 64'd1);
        check("bp C", bf16_out, {4{16'h4000}});
        @(posedge clk); #1;
        check("bp drained", 64'(out_valid), 64'd0);

        // Reset with two transactions in flight
        drive(4'h0, 4'h0, 20'h0, 20'h0, 8'd255, 8'd255);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(4'h0, 4'h0, {4{5'h1F}}, {4{5'h1F}}, 8'd127, 8'd127);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid pre valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst valid", 64'(out_valid), 64'd0);
        check("mid rst bf16", bf16_out, 64'd0);
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst count", 64'(ovf_count), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_cnt = 16'd0;
        check("mid release in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("mid no stale", 64'(out_valid), 64'd0);
        end
        run_one("post_rst", 4'h0, 4'h0, {4{5'h1F}}, {4{5'h1F}}, 8'd127, 8'd127,
                {4{16'h4078}}, 4'h0, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
